// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, fetches from a combinational instruction memory and holds the IF/ID register.
// Define IFETCH_PERF_COUNTERS_EN to add the perf_fetched / perf_bubbles saturating counters.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 101
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
`ifdef IFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    // state | meaning
    // BOOT  | one settling cycle after reset, no capture
    // RUN   | fetching, IF/ID advances on !id_valid || id_ready
    // FAULT | sticky fault, everything frozen until reset
    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic        adv;
    logic        pc_oor;
    logic [31:0] pc_plus4;

    assign adv      = !id_valid_q || id_ready;
    assign pc_oor   = {1'b0, pc_q} >= IMEM_LIMIT;
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Redirect path outranks both stall and the range check on the old PC.
                if (redirect_valid) begin
                    if (redirect_target[1:0] != 2'b00) begin
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_target;
                        id_valid_d = 1'b0;
                        state_d    = S_FAULT;
                    end else begin
                        pc_d       = redirect_target;
                        id_valid_d = 1'b0;
                    end
                end else if (adv) begin
                    if (pc_oor) begin
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                        id_valid_d = 1'b0;
                        state_d    = S_FAULT;
                    end else begin
                        id_instr_d    = imem_instr;
                        id_pc_d       = pc_q;
                        id_pc_plus4_d = pc_plus4;
                        id_valid_d    = 1'b1;
                        pc_d          = pc_plus4;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;

`ifdef IFETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;
    logic        seen_q;
    logic        fetch_inc;
    logic        bubble_inc;

    // The empty slot right after BOOT is not a bubble; only empty slots once fetching has begun are.
    assign fetch_inc  = (state_q == S_RUN) && !redirect_valid && adv && !pc_oor;
    assign bubble_inc = (state_q == S_RUN) && !id_valid_q && seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_bubbles_q <= 32'd0;
            seen_q         <= 1'b0;
        end else begin
            if (fetch_inc) begin
                seen_q <= 1'b1;
                if (perf_fetched_q != 32'hFFFF_FFFF) begin
                    perf_fetched_q <= perf_fetched_q + 32'd1;
                end
            end
            if (bubble_inc && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
